// File: rtl/data_mem_controller_if.sv
// Request, bus and response signals of the data memory controller.
// The slave modport is the controller's view; master is the pipeline/bus side.
interface data_mem_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    input  bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    output bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/data_mem_controller.sv
// Single-outstanding data memory controller: byte-lane alignment of stores,
// request/ack bus with bounded wait states, raw read word returned to the pipeline.
module data_mem_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  data_mem_controller_if.slave   io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_be;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_misaligned;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_timeout;

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = ofs[0];
      2'd2:    bad = (ofs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] f_lane_be(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << ofs;
      2'd1:    be = ofs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Right-justified store data replicated so every enabled lane sees it.
  function automatic logic [31:0] f_lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wdata[7:0]}};
      2'd1:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_accept     = io.req_valid && w_idle;
    w_misaligned = f_misaligned(io.req_size, io.req_addr[1:0]);
    w_be         = f_lane_be(io.req_size, io.req_addr[1:0]);
    w_wdata      = io.req_write ? f_lane_data(io.req_size, io.req_wdata) : 32'h0;
    w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_be    <= 4'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_misaligned) begin
              // Bad alignment never reaches the bus; report it directly.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state     <= S_BUS;
              r_bus_req   <= 1'b1;
              r_bus_we    <= io.req_write;
              r_bus_addr  <= {io.req_addr[31:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_be    <= w_be;
            end
          end
        end
        S_BUS: begin
          // An ack arriving on the timeout cycle still counts as success.
          if (io.bus_ack) begin
            r_state     <= S_RESP;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_bus_we ? 32'h0 : io.bus_rdata;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign io.req_ready = w_idle;
  assign io.stall     = !w_idle || io.req_valid;
  assign io.bus_req   = r_bus_req;
  assign io.bus_we    = r_bus_we;
  assign io.bus_addr  = r_bus_addr;
  assign io.bus_wdata = r_bus_wdata;
  assign io.bus_be    = r_bus_be;
  assign io.rsp_valid = r_rsp_valid;
  assign io.rsp_rdata = r_rsp_rdata;
  assign io.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: table of single transactions plus
// hand-written timeout, reset-abort and back-to-back sequences.
module tb_data_mem_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  data_mem_controller_if u_if ();

  data_mem_controller #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) u_dut (
    .clock (clk),
    .reset (rst),
    .io    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    u_if.req_valid = 1'b1;
    u_if.req_write = v.write;
    u_if.req_size  = v.size;
    u_if.req_addr  = v.addr;
    u_if.req_wdata = v.wdata;
    #1;
    chk({tag, "_ready"}, 32'(u_if.req_ready), 32'd1);
    chk({tag, "_stall_req"}, 32'(u_if.stall), 32'd1);
    tick();
    u_if.req_valid = 1'b0;
    u_if.req_wdata = 32'h0;
    if (v.err) begin
      chk({tag, "_mis_busreq"}, 32'(u_if.bus_req), 32'd0);
      chk({tag, "_mis_valid"}, 32'(u_if.rsp_valid), 32'd1);
      chk({tag, "_mis_err"}, 32'(u_if.rsp_err), 32'd1);
      chk({tag, "_mis_rdata"}, u_if.rsp_rdata, 32'h0);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        chk({tag, "_busreq"}, 32'(u_if.bus_req), 32'd1);
        chk({tag, "_we"}, 32'(u_if.bus_we), 32'(v.write));
        chk({tag, "_addr"}, u_if.bus_addr, v.baddr);
        chk({tag, "_be"}, 32'(u_if.bus_be), 32'(v.be));
        chk({tag, "_wdata"}, u_if.bus_wdata, v.bwdata);
        chk({tag, "_stall"}, 32'(u_if.stall), 32'd1);
        chk({tag, "_novalid"}, 32'(u_if.rsp_valid), 32'd0);
        if (w == v.waits) begin
          u_if.bus_ack   = 1'b1;
          u_if.bus_rdata = v.rdata;
        end
        tick();
        u_if.bus_ack   = 1'b0;
        u_if.bus_rdata = 32'h0BAD_F00D;
      end
      chk({tag, "_drop_req"}, 32'(u_if.bus_req), 32'd0);
      chk({tag, "_valid"}, 32'(u_if.rsp_valid), 32'd1);
      chk({tag, "_err"}, 32'(u_if.rsp_err), 32'd0);
      chk({tag, "_rdata"}, u_if.rsp_rdata, v.exp_rdata);
    end
    tick();
    chk({tag, "_pulse"}, 32'(u_if.rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(u_if.req_ready), 32'd1);
    chk({tag, "_idle_stall"}, 32'(u_if.stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_rd [4];
    int          k;
    int          cnt;
    logic        got;

    n_cmp = 0;
    n_bad = 0;

    //             we    sz    addr          wdata         w  rdata         err   be       baddr         bwdata        exp_rdata
    vecs[0] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5, 3, 32'h55AA55AA, 1'b0, 4'b1000, 32'h0000_0200, 32'hA5A5A5A5, 32'h0};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_0012, 32'h0000_BEEF, 1, 32'h55AA55AA, 1'b0, 4'b1100, 32'h0000_0010, 32'hBEEFBEEF, 32'h0};
    vecs[3] = '{1'b0, 2'd1, 32'h0000_0011, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
    vecs[4] = '{1'b0, 2'd0, 32'h0000_0401, 32'h1234_5677, 2, 32'h11223344, 1'b0, 4'b0010, 32'h0000_0400, 32'h0,        32'h11223344};
    vecs[5] = '{1'b1, 2'd2, 32'h0000_0008, 32'hCAFEF00D, 0, 32'h55AA55AA, 1'b0, 4'b1111, 32'h0000_0008, 32'hCAFEF00D, 32'h0};
    vecs[6] = '{1'b1, 2'd2, 32'h0000_000A, 32'h1111_2222, 0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
    vecs[7] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
    vecs[8] = '{1'b1, 2'd1, 32'h0000_0020, 32'h1234_ABCD, 0, 32'h55AA55AA, 1'b0, 4'b0011, 32'h0000_0020, 32'hABCDABCD, 32'h0};
    vecs[9] = '{1'b1, 2'd0, 32'h0000_0002, 32'hFF00_0077, 5, 32'h55AA55AA, 1'b0, 4'b0100, 32'h0000_0000, 32'h77777777, 32'h0};

    rst            = 1'b1;
    u_if.req_valid = 1'b0;
    u_if.req_write = 1'b0;
    u_if.req_size  = 2'd0;
    u_if.req_addr  = 32'h0;
    u_if.req_wdata = 32'h0;
    u_if.bus_ack   = 1'b0;
    u_if.bus_rdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busreq", 32'(u_if.bus_req), 32'd0);
    chk("rst_we", 32'(u_if.bus_we), 32'd0);
    chk("rst_addr", u_if.bus_addr, 32'h0);
    chk("rst_wdata", u_if.bus_wdata, 32'h0);
    chk("rst_be", 32'(u_if.bus_be), 32'd0);
    chk("rst_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("rst_err", 32'(u_if.rsp_err), 32'd0);
    chk("rst_rdata", u_if.rsp_rdata, 32'h0);
    chk("rst_ready", 32'(u_if.req_ready), 32'd1);
    chk("rst_stall", 32'(u_if.stall), 32'd0);

    // Stray ack while idle must not start anything.
    u_if.bus_ack = 1'b1;
    tick();
    u_if.bus_ack = 1'b0;
    chk("stray_ack_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("stray_ack_req", 32'(u_if.bus_req), 32'd0);

    for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

    // Timeout: no ack ever; bus_req must stay up exactly 16 cycles.
    u_if.req_valid = 1'b1;
    u_if.req_write = 1'b0;
    u_if.req_size  = 2'd2;
    u_if.req_addr  = 32'h0000_0300;
    tick();
    u_if.req_valid = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (u_if.rsp_valid) got = 1'b1;
      else begin
        if (u_if.bus_req) cnt++;
        tick();
      end
    end
    chk("to_seen", 32'(got), 32'd1);
    chk("to_req_cycles", 32'(cnt), 32'd16);
    chk("to_err", 32'(u_if.rsp_err), 32'd1);
    chk("to_rdata", u_if.rsp_rdata, 32'h0);
    chk("to_req_low", 32'(u_if.bus_req), 32'd0);
    tick();
    chk("to_idle", 32'(u_if.req_ready), 32'd1);

    // Ack on the 16th bus cycle wins over the timeout.
    u_if.req_valid = 1'b1;
    u_if.req_addr  = 32'h0000_0304;
    tick();
    u_if.req_valid = 1'b0;
    repeat (15) tick();
    chk("late_req_high", 32'(u_if.bus_req), 32'd1);
    u_if.bus_ack   = 1'b1;
    u_if.bus_rdata = 32'h13579BDF;
    tick();
    u_if.bus_ack   = 1'b0;
    chk("late_valid", 32'(u_if.rsp_valid), 32'd1);
    chk("late_err", 32'(u_if.rsp_err), 32'd0);
    chk("late_rdata", u_if.rsp_rdata, 32'h13579BDF);
    tick();

    // Reset while the bus is busy aborts the transaction silently.
    u_if.req_valid = 1'b1;
    u_if.req_write = 1'b1;
    u_if.req_addr  = 32'h0000_0500;
    u_if.req_wdata = 32'h0102_0304;
    tick();
    u_if.req_valid = 1'b0;
    tick();
    chk("rb_req_before", 32'(u_if.bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_req", 32'(u_if.bus_req), 32'd0);
    chk("rb_addr", u_if.bus_addr, 32'h0);
    chk("rb_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("rb_ready", 32'(u_if.req_ready), 32'd1);
    u_if.bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rb_no_rsp", 32'(u_if.rsp_valid), 32'd0);
    end
    u_if.bus_ack = 1'b0;

    // Back-to-back loads with req_valid held and a zero-wait bus.
    b2b_addr[0] = 32'h0000_0040; b2b_rd[0] = 32'hA0A0_0001;
    b2b_addr[1] = 32'h0000_0044; b2b_rd[1] = 32'hB0B0_0002;
    b2b_addr[2] = 32'h0000_0048; b2b_rd[2] = 32'hC0C0_0003;
    b2b_addr[3] = 32'h0000_004C; b2b_rd[3] = 32'hD0D0_0004;
    k = 0;
    u_if.req_write = 1'b0;
    u_if.req_size  = 2'd2;
    u_if.req_addr  = b2b_addr[0];
    u_if.req_valid = 1'b1;
    u_if.bus_ack   = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_ready", 32'(u_if.req_ready), 32'((c % 3) == 0));
      chk("b2b_stall", 32'(u_if.stall), 32'd1);
      tick();
      if ((c % 3) == 0) begin
        chk("b2b_bus_addr", u_if.bus_addr, b2b_addr[k]);
        chk("b2b_bus_req", 32'(u_if.bus_req), 32'd1);
        u_if.bus_rdata = b2b_rd[k];
        k++;
        u_if.req_addr = b2b_addr[k];
      end
      chk("b2b_valid", 32'(u_if.rsp_valid), 32'((c % 3) == 1));
      if ((c % 3) == 1) chk("b2b_rdata", u_if.rsp_rdata, b2b_rd[k-1]);
    end
    chk("b2b_idle_ready", 32'(u_if.req_ready), 32'd1);
    chk("b2b_idle_stall", 32'(u_if.stall), 32'd1);
    u_if.req_valid = 1'b0;
    u_if.bus_ack   = 1'b0;
    #1;
    chk("b2b_stall_drop", 32'(u_if.stall), 32'd0);
    tick();
    chk("b2b_end_req", 32'(u_if.bus_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
